// File: rtl/keypad_digit_loader.sv
// Debounces the keypad encoder's code/strobe pair and shifts each accepted
// digit into a right-justified BCD entry register.
module keypad_digit_loader #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [3:0]                   i_d_in,
  input  logic                         i_loadn,
  input  logic                         i_clear,
  input  logic                         i_lock,
  output logic [4*DIGITS-1:0]          o_digits,
  output logic [$clog2(DIGITS+1)-1:0]  o_digit_count,
  output logic                         o_new_digit,
  output logic                         o_err
);

  localparam int unsigned CntW   = $clog2(DEBOUNCE + 1);
  localparam int unsigned CountW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {StIdle, StDebounce, StHeld} state_e;

  state_e              r_state, w_state_d;
  logic [CntW-1:0]     r_cnt, w_cnt_d;
  logic [3:0]          r_cand, w_cand_d;
  logic [4*DIGITS-1:0] r_digits, w_digits_d;
  logic [CountW-1:0]   r_count, w_count_d;
  logic                r_new_digit, w_new_digit_d;
  logic                r_err, w_err_d;
  logic                w_commit;
  logic [3:0]          w_code;

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_cand_d      = r_cand;
    w_digits_d    = r_digits;
    w_count_d     = r_count;
    w_new_digit_d = 1'b0;
    w_err_d       = 1'b0;
    w_commit      = 1'b0;
    w_code        = r_cand;

    unique case (r_state)
      StIdle: begin
        if (!i_loadn) begin
          w_cand_d = i_d_in;
          w_cnt_d  = CntW'(1);
          if (DEBOUNCE == 1) begin
            w_commit  = 1'b1;
            w_code    = i_d_in;
            w_state_d = StHeld;
          end else begin
            w_state_d = StDebounce;
          end
        end
      end
      StDebounce: begin
        // A changed code aborts; it is picked up again from IDLE next edge.
        if (i_loadn || (i_d_in != r_cand)) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
          if ((32'(r_cnt) + 32'd1) == DEBOUNCE) begin
            w_commit  = 1'b1;
            w_state_d = StHeld;
          end
        end
      end
      StHeld: begin
        if (i_loadn) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_commit) begin
      if (w_code <= 4'd9) begin
        w_digits_d    = {r_digits[4*DIGITS-5:0], w_code};
        w_new_digit_d = 1'b1;
        if (r_count != CountW'(DIGITS)) begin
          w_count_d = r_count + CountW'(1);
        end
      end else begin
        w_err_d = 1'b1;
      end
    end

    // Clear beats lock beats the FSM; both park in HELD while a key is down
    // so a press straddling them is never registered.
    if (i_clear || i_lock) begin
      w_state_d     = i_loadn ? StIdle : StHeld;
      w_cnt_d       = '0;
      w_digits_d    = i_clear ? '0 : r_digits;
      w_count_d     = i_clear ? '0 : r_count;
      w_new_digit_d = 1'b0;
      w_err_d       = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_cand      <= '0;
      r_digits    <= '0;
      r_count     <= '0;
      r_new_digit <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_cand      <= w_cand_d;
      r_digits    <= w_digits_d;
      r_count     <= w_count_d;
      r_new_digit <= w_new_digit_d;
      r_err       <= w_err_d;
    end
  end

  assign o_digits      = r_digits;
  assign o_digit_count = r_count;
  assign o_new_digit   = r_new_digit;
  assign o_err         = r_err;

endmodule
